fwd_hazard_unit: RTL



---
 rtl/rv32i_types.sv | 31 +++
 rtl/fwd_hazard_unit_chk.sv | 22 ++
 rtl/load_extend.sv | 30 +++
 rtl/fwd_hazard_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: writeback mux select and forwarding source tags.
package rv32i_types;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } fwd_src_e;

  function automatic logic is_load(input regfilemux_sel_t sel);
    case (sel)
      rf_lw, rf_lb, rf_lbu, rf_lh, rf_lhu: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_chk.sv
// Protocol checks on the long-latency scoreboard interface.
module fwd_hazard_unit_chk (
  input logic        clk,
  input logic        rst,
  input logic        issue_long_valid,
  input logic [4:0]  issue_long_rd,
  input logic        long_wb_valid,
  input logic [4:0]  long_wb_rd,
  input logic [31:0] busy,
  input logic        sb_full
);

  // Flag issues that would overflow the scoreboard and writebacks of idle registers
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(long_wb_valid && !busy[long_wb_rd]));
      assert (!(issue_long_valid && (issue_long_rd != 5'd0) && sb_full &&
                !(long_wb_valid && busy[long_wb_rd])));
    end
  end

endmodule

// File: rtl/load_extend.sv
// Lane-selects a byte/half from a raw memory word and sign/zero-extends it to XLEN.
module load_extend
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  regfilemux_sel_t   sel,
  input  logic [1:0]        addr,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction and extension by load flavour
  always_comb begin
    byte_s = rdata[{addr, 3'b000} +: 8];
    half_s = rdata[{addr[1], 4'b0000} +: 16];
    ext    = rdata;
    case (sel)
      rf_lb:   ext = {{(XLEN-8){byte_s[7]}}, byte_s};
      rf_lbu:  ext = {{(XLEN-8){1'b0}}, byte_s};
      rf_lh:   ext = {{(XLEN-16){half_s[15]}}, half_s};
      rf_lhu:  ext = {{(XLEN-16){1'b0}}, half_s};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding with stall-hold, plus load-use and long-latency scoreboard hazard detection.
module fwd_hazard_unit
  import rv32i_types::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int XLEN           = 32,
  parameter int MAX_PENDING    = 4,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_stall,
  input  logic [NUM_SRC*5-1:0]    ex_src_addr,
  input  logic [NUM_SRC*XLEN-1:0] ex_src_data,
  input  logic [NUM_SRC*5-1:0]    id_src_addr,
  input  logic [4:0]              id_rd,
  input  logic                    id_ex_is_load,
  input  logic [4:0]              id_ex_rd,
  input  logic                    ex_mem_valid,
  input  logic                    mem_wb_valid,
  input  logic [4:0]              ex_mem_rd,
  input  logic [4:0]              mem_wb_rd,
  input  regfilemux_sel_t         ex_mem_sel,
  input  regfilemux_sel_t         mem_wb_sel,
  input  logic [XLEN-1:0]         ex_mem_alu_out,
  input  logic [XLEN-1:0]         mem_wb_alu_out,
  input  logic [XLEN-1:0]         ex_mem_rdata,
  input  logic [XLEN-1:0]         mem_wb_rdata,
  input  logic                    issue_long_valid,
  input  logic [4:0]              issue_long_rd,
  input  logic                    long_wb_valid,
  input  logic [4:0]              long_wb_rd,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic                    id_stall,
  output logic                    sb_full
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  logic [XLEN-1:0] exm_ext_s, mwb_ext_s, exm_val_s, mwb_val_s;

  load_extend #(.XLEN(XLEN)) u_ext_exm (
    .sel(ex_mem_sel), .addr(ex_mem_alu_out[1:0]), .rdata(ex_mem_rdata), .ext(exm_ext_s)
  );
  load_extend #(.XLEN(XLEN)) u_ext_mwb (
    .sel(mem_wb_sel), .addr(mem_wb_alu_out[1:0]), .rdata(mem_wb_rdata), .ext(mwb_ext_s)
  );

  // Non-load selects already carry their final value in alu_out
  assign exm_val_s = is_load(ex_mem_sel) ? exm_ext_s : ex_mem_alu_out;
  assign mwb_val_s = is_load(mem_wb_sel) ? mwb_ext_s : mem_wb_alu_out;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [4:0]      addr_s;
    fwd_src_e        src_s;
    logic [XLEN-1:0] live_s;
    logic            hold_valid_r;
    logic [XLEN-1:0] hold_data_r;

    assign addr_s = ex_src_addr[i*5 +: 5];

    // Forward source priority: EX_MEM, then MEM_WB, then regfile
    always_comb begin
      src_s = FWD_RF;
      if ((addr_s != 5'd0) && ex_mem_valid && (ex_mem_rd == addr_s)) begin
        src_s = FWD_EX_MEM;
      end else if ((addr_s != 5'd0) && mem_wb_valid && (mem_wb_rd == addr_s)) begin
        src_s = FWD_MEM_WB;
      end else begin
        src_s = FWD_RF;
      end
      case (src_s)
        FWD_EX_MEM: live_s = exm_val_s;
        FWD_MEM_WB: live_s = mwb_val_s;
        default:    live_s = ex_src_data[i*XLEN +: XLEN];
      endcase
    end

    // Capture the operand on the first stalled cycle, release when the stall drops
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_valid_r <= 1'b0;
        hold_data_r  <= '0;
      end else if (ex_stall && !hold_valid_r) begin
        hold_valid_r <= 1'b1;
        hold_data_r  <= live_s;
      end else if (!ex_stall) begin
        hold_valid_r <= 1'b0;
      end
    end

    assign fwd_data[i*XLEN +: XLEN] = (hold_valid_r && ex_stall) ? hold_data_r : live_s;
  end

  logic [31:0]      busy_r, busy_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             sb_full_r;
  logic             wb_ok_s, set_ok_s;
  logic             lu_hit_s, raw_s, waw_s, load_use_s;

  // Scoreboard next state; illegal requests leave state untouched
  always_comb begin
    wb_ok_s  = long_wb_valid && busy_r[long_wb_rd];
    set_ok_s = issue_long_valid && (issue_long_rd != 5'd0) &&
               ((count_r != MAX_CNT) || wb_ok_s);
    busy_nxt_s = busy_r;
    busy_nxt_s[long_wb_rd]    = wb_ok_s  ? 1'b0 : busy_nxt_s[long_wb_rd];
    busy_nxt_s[issue_long_rd] = set_ok_s ? 1'b1 : busy_nxt_s[issue_long_rd];
    case ({set_ok_s, wb_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Scoreboard state; sb_full tracks the count it is registered alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 32'd0;
      count_r   <= '0;
      sb_full_r <= 1'b0;
    end else begin
      busy_r    <= busy_nxt_s;
      count_r   <= count_nxt_s;
      sb_full_r <= (count_nxt_s == MAX_CNT);
    end
  end

  // Hazard terms
  always_comb begin
    lu_hit_s = 1'b0;
    raw_s    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lu_hit_s = lu_hit_s | (id_src_addr[i*5 +: 5] == id_ex_rd);
      raw_s    = raw_s | ((id_src_addr[i*5 +: 5] != 5'd0) && busy_r[id_src_addr[i*5 +: 5]]);
    end
    waw_s      = (id_rd != 5'd0) && busy_r[id_rd];
    load_use_s = (LOAD_USE_STALL != 0) && id_ex_is_load && (id_ex_rd != 5'd0) && lu_hit_s;
  end

  assign id_stall = load_use_s | raw_s | waw_s | (sb_full_r & issue_long_valid);
  assign sb_full  = sb_full_r;

  fwd_hazard_unit_chk u_chk (
    .clk(clk), .rst(rst),
    .issue_long_valid(issue_long_valid), .issue_long_rd(issue_long_rd),
    .long_wb_valid(long_wb_valid), .long_wb_rd(long_wb_rd),
    .busy(busy_r), .sb_full(sb_full_r)
  );

endmodule
